// File: rtl/u_ins_loader.sv
// rtl/u_ins_loader.sv - byte-serial, length-prefixed loader for the instruction-memory write port
module u_ins_loader #(
  parameter int MAX_WORDS   = 1024,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        i_sys_clock,
  input  logic        i_sys_reset,
  input  logic [7:0]  i_u_ins_loader_byte,
  input  logic        i_u_ins_loader_byte_valid,
  output logic        o_u_ins_loader_byte_ready,
  input  logic        i_u_ins_loader_start,
  output logic [31:0] o_u_ins_loader_write_ins,
  output logic        o_u_ins_loader_ins_wr,
  output logic        o_u_ins_loader_cpu_hold,
  output logic        o_u_ins_loader_done,
  output logic        o_u_ins_loader_error,
  output logic [15:0] o_u_ins_loader_word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_FLUSH, S_DONE, S_ERR
  } state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [23:0] shift;
  logic [1:0]  lane;
  logic [31:0] idle_cnt;

  logic        accept;
  logic        timeout;
  logic [15:0] n_full;
  logic [15:0] cnt_next;

  assign o_u_ins_loader_byte_ready = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA);
  assign accept   = i_u_ins_loader_byte_valid && o_u_ins_loader_byte_ready;
  assign timeout  = (idle_cnt == TO_LAST);
  assign n_full   = {i_u_ins_loader_byte, len_lo};
  assign cnt_next = o_u_ins_loader_word_cnt + 16'd1;

  always_ff @(posedge i_sys_clock or negedge i_sys_reset) begin
    if (!i_sys_reset) begin
      state                    <= S_IDLE;
      len_lo                   <= '0;
      len                      <= '0;
      shift                    <= '0;
      lane                     <= '0;
      idle_cnt                 <= '0;
      o_u_ins_loader_write_ins <= '0;
      o_u_ins_loader_ins_wr    <= 1'b0;
      o_u_ins_loader_cpu_hold  <= 1'b1;
      o_u_ins_loader_done      <= 1'b0;
      o_u_ins_loader_error     <= 1'b0;
      o_u_ins_loader_word_cnt  <= '0;
    end else begin
      o_u_ins_loader_ins_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          state    <= S_LEN0;
          idle_cnt <= '0;
        end
        S_LEN0: begin
          if (accept) begin
            len_lo   <= i_u_ins_loader_byte;
            idle_cnt <= '0;
            state    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (accept) begin
            len      <= n_full;
            idle_cnt <= '0;
            lane     <= '0;
            if (n_full == 16'd0) begin
              state                   <= S_DONE;
              o_u_ins_loader_done     <= 1'b1;
              o_u_ins_loader_cpu_hold <= 1'b0;
            end else if ({1'b0, n_full} > 17'(MAX_WORDS)) begin
              state                <= S_ERR;
              o_u_ins_loader_error <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end else if (timeout) begin
            state                <= S_ERR;
            o_u_ins_loader_error <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end
        S_DATA: begin
          if (accept) begin
            idle_cnt <= '0;
            shift    <= {i_u_ins_loader_byte, shift[23:8]};
            lane     <= lane + 2'd1;
            // Fourth byte of a word: publish it on the same edge it arrives.
            if (lane == 2'd3) begin
              o_u_ins_loader_write_ins <= {i_u_ins_loader_byte, shift};
              o_u_ins_loader_ins_wr    <= 1'b1;
              o_u_ins_loader_word_cnt  <= cnt_next;
              if (cnt_next == len) state <= S_FLUSH;
            end
          end else if (timeout) begin
            state                <= S_ERR;
            o_u_ins_loader_error <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end
        S_FLUSH: begin
          state                   <= S_DONE;
          o_u_ins_loader_done     <= 1'b1;
          o_u_ins_loader_cpu_hold <= 1'b0;
        end
        S_DONE, S_ERR: begin
          if (i_u_ins_loader_start) begin
            state                   <= S_LEN0;
            o_u_ins_loader_done     <= 1'b0;
            o_u_ins_loader_error    <= 1'b0;
            o_u_ins_loader_word_cnt <= '0;
            o_u_ins_loader_cpu_hold <= 1'b1;
            lane                    <= '0;
            idle_cnt                <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_u_ins_loader.sv
// tb/tb_u_ins_loader.sv - self-checking bench for u_ins_loader
module tb_u_ins_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic        start = 1'b0;
  logic [31:0] write_ins;
  logic        ins_wr;
  logic        hold;
  logic        done;
  logic        err;
  logic [15:0] cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_idx = 0;
  logic [31:0] exp_q[$];
  int strobe_cyc[$];

  u_ins_loader #(.MAX_WORDS(1024), .TIMEOUT_CYC(8)) dut (
    .i_sys_clock              (clk),
    .i_sys_reset              (rst_n),
    .i_u_ins_loader_byte      (byte_in),
    .i_u_ins_loader_byte_valid(valid),
    .o_u_ins_loader_byte_ready(ready),
    .i_u_ins_loader_start     (start),
    .o_u_ins_loader_write_ins (write_ins),
    .o_u_ins_loader_ins_wr    (ins_wr),
    .o_u_ins_loader_cpu_hold  (hold),
    .o_u_ins_loader_done      (done),
    .o_u_ins_loader_error     (err),
    .o_u_ins_loader_word_cnt  (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every cycle: any strobe must match the next word the model expects.
  task automatic tick();
    logic [31:0] w;
    @(posedge clk);
    #1;
    cyc++;
    if (ins_wr) begin
      strobe_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        exp_idx++;
        check("write_ins", write_ins, w);
        check("word_cnt_at_wr", 32'(cnt), 32'(exp_idx));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    byte_in = b;
    valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      acc = ready;
      tick();
      if (acc) break;
    end
    if (!acc) check("accept_budget", 32'd0, 32'd1);
    valid = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_done", 32'(done), 32'd0);
    check("start_err", 32'(err), 32'd0);
    check("start_cnt", 32'(cnt), 32'd0);
    check("start_hold", 32'(hold), 32'd1);
    check("start_ready", 32'(ready), 32'd1);
  endtask

  task automatic load_frame(input int n, input int maxgap);
    logic [7:0] bytes[$];
    logic [31:0] w;
    bool_wait: begin end
    exp_idx = 0;
    bytes.push_back(8'(n % 256));
    bytes.push_back(8'(n / 256));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      exp_q.push_back(w);
      for (int k = 0; k < 4; k++) bytes.push_back(8'((w >> (8 * k)) % 256));
    end
    foreach (bytes[i]) begin
      repeat ($urandom_range(0, maxgap)) tick();
      send_byte(bytes[i]);
    end
    for (int i = 0; i < 20 && !done; i++) tick();
    check("frame_done", 32'(done), 32'd1);
    check("frame_hold", 32'(hold), 32'd0);
    check("frame_cnt", 32'(cnt), 32'(n));
    check("frame_pending", 32'(exp_q.size()), 32'd0);
    check("frame_ready", 32'(ready), 32'd0);
  endtask

  initial begin
    logic [7:0] seq[$];

    // Reset state
    tick();
    check("rst_write_ins", write_ins, 32'd0);
    check("rst_ins_wr", 32'(ins_wr), 32'd0);
    check("rst_hold", 32'(hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    check("idle_ready", 32'(ready), 32'd0);
    tick();
    check("len0_ready", 32'(ready), 32'd1);

    // Normal load, back-to-back
    exp_idx = 0;
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'hDEADBEEF);
    strobe_cyc.delete();
    seq = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    foreach (seq[i]) send_byte(seq[i]);
    check("normal_done_early", 32'(done), 32'd0);
    tick();
    check("normal_done", 32'(done), 32'd1);
    check("normal_hold", 32'(hold), 32'd0);
    check("normal_cnt", 32'(cnt), 32'd2);
    check("normal_strobes", 32'(strobe_cyc.size()), 32'd2);
    if (strobe_cyc.size() == 2)
      check("normal_strobe_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd4);

    // Zero length
    start_pulse();
    strobe_cyc.delete();
    send_byte(8'h00);
    send_byte(8'h00);
    check("zero_done", 32'(done), 32'd1);
    check("zero_hold", 32'(hold), 32'd0);
    check("zero_strobes", 32'(strobe_cyc.size()), 32'd0);

    // Oversize length (1025)
    start_pulse();
    send_byte(8'h01);
    send_byte(8'h04);
    repeat (3) tick();
    check("over_err", 32'(err), 32'd1);
    check("over_hold", 32'(hold), 32'd1);
    check("over_ready", 32'(ready), 32'd0);
    check("over_strobes", 32'(strobe_cyc.size()), 32'd0);

    // Timeout mid-word
    start_pulse();
    seq = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    foreach (seq[i]) send_byte(seq[i]);
    repeat (7) tick();
    check("to_err_early", 32'(err), 32'd0);
    tick();
    check("to_err", 32'(err), 32'd1);
    check("to_cnt", 32'(cnt), 32'd0);
    check("to_hold", 32'(hold), 32'd1);
    check("to_strobes", 32'(strobe_cyc.size()), 32'd0);

    // Gaps, then restart with a one-word image
    start_pulse();
    load_frame(3, 5);
    start_pulse();
    exp_idx = 0;
    exp_q.push_back(32'h11223344);
    seq = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    foreach (seq[i]) send_byte(seq[i]);
    tick();
    check("restart_done", 32'(done), 32'd1);
    check("restart_cnt", 32'(cnt), 32'd1);

    // Reset in the middle of word 2
    start_pulse();
    exp_idx = 0;
    exp_q.push_back(32'hCAFEF00D);
    seq = '{8'h03, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h11, 8'h22};
    foreach (seq[i]) send_byte(seq[i]);
    check("mid_cnt", 32'(cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_write_ins", write_ins, 32'd0);
    check("mid_rst_hold", 32'(hold), 32'd1);
    check("mid_rst_cnt", 32'(cnt), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_ins_wr", 32'(ins_wr), 32'd0);
    tick();
    rst_n = 1'b1;
    check("post_rst_ready0", 32'(ready), 32'd0);
    tick();
    check("post_rst_ready1", 32'(ready), 32'd1);
    load_frame(2, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/u_ins_loader.md
# u_ins_loader

Byte-serial program loader that sits directly upstream of the chip's instruction-memory write port. It accepts a length-prefixed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is presented with a one-cycle write strobe on the `i_c_write_ins` / `i_c_ins_wr` path. The CPU is held in reset until the whole image is written.

## Interface

Parameters:
- `MAX_WORDS`, default 1024: largest accepted image length, in words.
- `TIMEOUT_CYC`, default 65535: number of idle cycles allowed mid-frame before the loader aborts.

Ports:
- `i_sys_clock`  in  1  system clock; all state changes on its rising edge.
- `i_sys_reset`  in  1  active-low, asynchronous reset.
- `i_u_ins_loader_byte`  in  8  stream byte.
- `i_u_ins_loader_byte_valid`  in  1  stream byte is valid.
- `o_u_ins_loader_byte_ready`  out  1  loader accepts a byte this cycle; combinational from state.
- `i_u_ins_loader_start`  in  1  one-cycle pulse that re-arms the loader; honoured only in DONE or ERR.
- `o_u_ins_loader_write_ins`  out  32  assembled instruction word; drives `i_c_write_ins`.
- `o_u_ins_loader_ins_wr`  out  1  one-cycle write strobe; drives `i_c_ins_wr`.
- `o_u_ins_loader_cpu_hold`  out  1  active-high CPU hold-in-reset request.
- `o_u_ins_loader_done`  out  1  image loaded; sticky until start or reset.
- `o_u_ins_loader_error`  out  1  load aborted; sticky until start or reset.
- `o_u_ins_loader_word_cnt`  out  16  number of words written so far.

## Operation

Frame format:
- Bytes 0–1: N, the word count, 16-bit little-endian.
- Then 4·N bytes; each word is little-endian (first byte lands in bits [7:0]).

Handshake:
- A byte transfers on any rising edge where valid and ready are both 1.
- Valid may stay high or have gaps. Bytes offered while ready is 0 are not consumed.

States:
- **IDLE**
  - Entered from reset.
  - Always moves to LEN0 on the next edge.
  - Ready is 0.
- **LEN0**
  - Ready is 1.
  - On accept, latch N[7:0] and go to LEN1.
  - No timeout in this state.
- **LEN1**
  - Ready is 1.
  - On accept, latch N[15:8], then choose the next state:
    - if N = 0: DONE;
    - if N > MAX_WORDS: ERR;
    - otherwise: DATA, with the byte-lane counter at 0.
- **DATA**
  - Ready is 1.
  - Each accepted byte is shifted in as shift ← {byte, shift[31:8]} and the 2-bit lane counter increments.
  - On the 4th byte of a word, the same edge does all of the following:
    - write_ins ← {byte, shift[31:8]};
    - ins_wr ← 1 for exactly one cycle;
    - word_cnt increments;
    - lane counter wraps to 0.
  - If the new word_cnt equals N, go to FLUSH; otherwise stay in DATA.
- **FLUSH**
  - Ready is 0.
  - Lasts one cycle, so the last memory write completes.
  - Then go to DONE.
- **DONE**
  - Ready is 0.
  - done = 1, hold = 0.
- **ERR**
  - Ready is 0.
  - error = 1, hold stays 1.

Timeout:
- Applies in LEN1 and DATA only.
- An idle counter clears on every accepted byte and on every state entry.
- When the counter reaches TIMEOUT_CYC without an accept, go to ERR.
- Bytes already written stay written; word_cnt keeps its value.

Start:
- In DONE or ERR, a start pulse moves the loader to LEN0 on the next edge and, on that same edge:
  - clears done, error, word_cnt and the lane counter;
  - sets hold = 1.
- In any other state, start is ignored.

Output hold rules:
- write_ins holds its value between strobes.
- ins_wr is 0 in every state except the single cycle after a word completes.

## Timing

Reset values (asserted immediately, asynchronously):
- state = IDLE
- write_ins = 0, ins_wr = 0
- cpu_hold = 1
- done = 0, error = 0
- word_cnt = 0
- byte_ready = 0

Latencies:
- Reset release to first ready = 1: one edge (IDLE → LEN0).
- Accept of 4th byte of a word to ins_wr = 1: the strobe is visible in the cycle following that edge.
- Final strobe to done = 1 / hold = 0: one cycle later (FLUSH → DONE edge).

Reset mid-load:
- Returns to the reset values above.
- Any partial word is discarded.
- Memory contents are not touched by this block.

Full-rate transfer:
- One byte accepted per cycle back-to-back gives one strobe every 4 cycles.

## Test plan

- **Normal load.** Stream 02 00 | 78 56 34 12 | EF BE AD DE with valid high continuously. Required: ins_wr pulses with write_ins = 0x12345678 then 0xDEADBEEF, 4 cycles apart; word_cnt = 2; done = 1 and hold = 0 one cycle after the second strobe.
- **Zero length.** Stream 00 00. Required: no ins_wr pulse; done = 1 and hold = 0 directly after the LEN1 accept.
- **Oversize length.** With MAX_WORDS = 1024, stream 01 04 (N = 1025). Required: error = 1, hold = 1, no strobe, ready = 0.
- **Timeout.** Set TIMEOUT_CYC = 8; stream 01 00 AA BB, then hold valid low. Required: error = 1 exactly 8 cycles after the BB accept; word_cnt = 0; no strobe.
- **Gaps and restart.** Insert random valid gaps shorter than the timeout into a 3-word load; after done, pulse start and load one word (01 00 44 33 22 11). Required: correct words 0x11223344 etc. on each strobe; start clears done and word_cnt and raises hold.
- **Reset mid-load.** Drive i_sys_reset low for 1 cycle in the middle of word 2. Required: all outputs at reset values immediately; after release, a fresh frame loads correctly from word_cnt = 0.
